// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALUOp and funct encodings,
// internal ALU operation codes, multiplier FSM states, decode helpers.
package mips_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_MUL,
        ALU_BAD
    } alu_op_t;

    // ALU_BAD marks an unknown funct: result 0, no register write.
    function automatic alu_op_t funct_decode(
        input logic [5:0] funct,
        input logic       mul_en
    );
        alu_op_t op;
        op = ALU_BAD;
        unique case (1'b1)
            funct == FUNCT_ADD:           op = ALU_ADD;
            funct == FUNCT_SUB:           op = ALU_SUB;
            funct == FUNCT_AND:           op = ALU_AND;
            funct == FUNCT_OR:            op = ALU_OR;
            funct == FUNCT_NOR:           op = ALU_NOR;
            funct == FUNCT_SLT:           op = ALU_SLT;
            mul_en && funct == FUNCT_MUL: op = ALU_MUL;
            default:                      op = ALU_BAD;
        endcase
        return op;
    endfunction

    function automatic alu_op_t alu_decode(
        input logic [2:0] alu_op,
        input logic [5:0] funct,
        input logic       mul_en
    );
        alu_op_t op;
        op = ALU_ADD;
        unique case (alu_op)
            ALUOP_ADD:   op = ALU_ADD;
            ALUOP_SUB:   op = ALU_SUB;
            ALUOP_RTYPE: op = funct_decode(funct, mul_en);
            ALUOP_AND:   op = ALU_AND;
            ALUOP_OR:    op = ALU_OR;
            ALUOP_SLT:   op = ALU_SLT;
            default:     op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier: IDLE -> MUL -> DONE -> IDLE, one step per hit edge.
// Ports: clock, reset_n, hit, start, op_a, op_b, busy, done, product. Built only with EXECUTE_MULT_EN.
`ifdef EXECUTE_MULT_EN
module iterative_multiplier
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hit,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_t        state;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;

    // Reset gates busy so a mul sitting on the inputs cannot stall during reset.
    assign busy = reset_n
                & (((state == MUL_IDLE) & start) | (state == MUL_RUN));
    assign done    = (state == MUL_DONE);
    assign product = acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MUL_IDLE;
            counter <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (hit) begin
            unique case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand   <= op_a;
                        mplier  <= op_b;
                        acc     <= '0;
                        counter <= '0;
                        state   <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                end
                default: begin
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule
`endif

// File: rtl/execute_stage.sv
// EX stage + EX/MEM register: ALU decode, ALU, beq resolution, optional mul.
// Macro EXECUTE_MULT_EN enables the multi-cycle multiplier (funct 18) and busy.
module execute_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hit,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] sign_extended_immediate,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic [2:0]        ALUOp,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] next_PC,
    output logic              busy,
    output logic [DATA_W-1:0] alu_result_output,
    output logic [DATA_W-1:0] write_data_output,
    output logic [4:0]        write_register_output,
    output logic              MemtoReg_output,
    output logic              RegWrite_output,
    output logic              MemRead_output,
    output logic              MemWrite_output,
    output logic              branch_taken_output,
    output logic [DATA_W-1:0] branch_target_output
);

`ifdef EXECUTE_MULT_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    alu_op_t           op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mul_product;
    logic              mul_done;
    logic              zero;
    logic              reg_write_ok;
    logic [4:0]        write_register;
    logic [DATA_W-1:0] branch_target;

    assign op    = alu_decode(ALUOp, funct, MUL_EN);
    assign alu_b = ALUSrc ? sign_extended_immediate : read_data_2;

`ifdef EXECUTE_MULT_EN
    logic mul_start;

    assign mul_start = (op == ALU_MUL);

    iterative_multiplier #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .hit     (hit),
        .start   (mul_start),
        .op_a    (read_data_1),
        .op_b    (alu_b),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    logic unused_cfg;

    assign unused_cfg  = ^MUL_CYCLES;
    assign busy        = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_comb begin
        alu_result = '0;
        unique case (op)
            ALU_ADD: alu_result = read_data_1 + alu_b;
            ALU_SUB: alu_result = read_data_1 - alu_b;
            ALU_AND: alu_result = read_data_1 & alu_b;
            ALU_OR:  alu_result = read_data_1 | alu_b;
            ALU_NOR: alu_result = ~(read_data_1 | alu_b);
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}},
                                   $signed(read_data_1) < $signed(alu_b)};
            ALU_MUL: alu_result = mul_done ? mul_product : '0;
            ALU_BAD: alu_result = '0;
            default: alu_result = '0;
        endcase
    end

    assign zero           = (alu_result == '0);
    assign reg_write_ok   = RegWrite & (op != ALU_BAD);
    assign write_register = RegDst ? rd : rt;
    assign branch_target  = next_PC + (sign_extended_immediate << 2);

    // While busy the register takes a bubble: controls clear, data holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_output     <= '0;
            write_data_output     <= '0;
            write_register_output <= '0;
            MemtoReg_output       <= 1'b0;
            RegWrite_output       <= 1'b0;
            MemRead_output        <= 1'b0;
            MemWrite_output       <= 1'b0;
            branch_taken_output   <= 1'b0;
            branch_target_output  <= '0;
        end else if (hit) begin
            if (busy) begin
                MemtoReg_output     <= 1'b0;
                RegWrite_output     <= 1'b0;
                MemRead_output      <= 1'b0;
                MemWrite_output     <= 1'b0;
                branch_taken_output <= 1'b0;
            end else begin
                alu_result_output     <= alu_result;
                write_data_output     <= read_data_2;
                write_register_output <= write_register;
                MemtoReg_output       <= MemtoReg;
                RegWrite_output       <= reg_write_ok;
                MemRead_output        <= MemRead;
                MemWrite_output       <= MemWrite;
                branch_taken_output   <= Branch & zero;
                branch_target_output  <= branch_target;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table plus freeze,
// reset and (with EXECUTE_MULT_EN) multiply sequences.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        hit;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] sign_extended_immediate;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, Branch;
    logic [2:0]  ALUOp;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic [31:0] next_PC;
    logic        busy;
    logic [31:0] alu_result_output;
    logic [31:0] write_data_output;
    logic [4:0]  write_register_output;
    logic        MemtoReg_output, RegWrite_output;
    logic        MemRead_output, MemWrite_output;
    logic        branch_taken_output;
    logic [31:0] branch_target_output;

    int checks   = 0;
    int failures = 0;

    execute_stage dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .hit                     (hit),
        .read_data_1             (read_data_1),
        .read_data_2             (read_data_2),
        .sign_extended_immediate (sign_extended_immediate),
        .RegDst                  (RegDst),
        .ALUSrc                  (ALUSrc),
        .MemtoReg                (MemtoReg),
        .RegWrite                (RegWrite),
        .MemRead                 (MemRead),
        .MemWrite                (MemWrite),
        .Branch                  (Branch),
        .ALUOp                   (ALUOp),
        .rt                      (rt),
        .rd                      (rd),
        .funct                   (funct),
        .next_PC                 (next_PC),
        .busy                    (busy),
        .alu_result_output       (alu_result_output),
        .write_data_output       (write_data_output),
        .write_register_output   (write_register_output),
        .MemtoReg_output         (MemtoReg_output),
        .RegWrite_output         (RegWrite_output),
        .MemRead_output          (MemRead_output),
        .MemWrite_output         (MemWrite_output),
        .branch_taken_output     (branch_taken_output),
        .branch_target_output    (branch_target_output)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        src;
        logic        dst;
        logic        br;
        logic        rw;
        logic [2:0]  ctl;
        logic [31:0] npc;
        logic [31:0] e_alu;
        logic [4:0]  e_wr;
        logic        e_rw;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src,
                         input logic dst, input logic br, input logic rw,
                         input logic [2:0] ctl, input logic [31:0] npc);
        ALUOp                   = op;
        funct                   = f;
        read_data_1             = a;
        read_data_2             = b;
        sign_extended_immediate = im;
        ALUSrc                  = src;
        RegDst                  = dst;
        Branch                  = br;
        RegWrite                = rw;
        {MemtoReg, MemRead, MemWrite} = ctl;
        next_PC                 = npc;
    endtask

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".alu"}, alu_result_output, 0);
        chk({tag, ".wdata"}, write_data_output, 0);
        chk({tag, ".wreg"}, write_register_output, 0);
        chk({tag, ".ctl"}, {MemtoReg_output, RegWrite_output,
                            MemRead_output, MemWrite_output}, 0);
        chk({tag, ".taken"}, branch_taken_output, 0);
        chk({tag, ".target"}, branch_target_output, 0);
    endtask

    // Runs one multiply already on the inputs; gap_at>0 freezes 5 edges there.
    task automatic run_mul(input string tag, input int gap_at,
                           input int exp_cycles, input logic [31:0] exp_p);
        int  n;
        bit  bubble_ok;
        n = 0;
        bubble_ok = 1;
        chk({tag, ".busy_start"}, busy, 1);
        while (busy === 1'b1 && n < 200) begin
            edge1();
            n++;
            if (gap_at > 0 && n == gap_at) hit = 1'b0;
            if (gap_at > 0 && n == gap_at + 5) hit = 1'b1;
            if ({MemtoReg_output, RegWrite_output, MemRead_output,
                 MemWrite_output, branch_taken_output} !== 5'b0)
                bubble_ok = 0;
        end
        chk({tag, ".busy_cycles"}, n, exp_cycles);
        chk({tag, ".bubble"}, bubble_ok, 1);
        edge1();
        chk({tag, ".product"}, alu_result_output, exp_p);
        chk({tag, ".regwrite"}, RegWrite_output, 1);
        chk({tag, ".wreg"}, write_register_output, 5);
    endtask

    initial begin
        rt = 5'd9;
        rd = 5'd5;
        hit = 1'b1;
        reset_n = 1'b0;
        drive(3'($urandom), 6'($urandom), $urandom, $urandom, $urandom,
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), $urandom);
        #2;
        chk_all_zero("reset");
        drive(3'b000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        #1 reset_n = 1'b1;
        edge1();

        //          name    op      funct  a             b             imm           s  d  br rw ctl     npc           e_alu         wr e_rw tk tgt
        vecs.push_back('{"add",   3'b010, 6'h20, 111,          222,          0,            0, 1, 0, 1, 3'b000, 32'h100,      333,          5, 1, 0, 32'h100});
        vecs.push_back('{"beq_t", 3'b001, 6'h00, 7,            7,            3,            0, 0, 1, 0, 3'b000, 777,          0,            9, 0, 1, 789});
        vecs.push_back('{"beq_n", 3'b001, 6'h00, 7,            8,            3,            0, 0, 1, 0, 3'b000, 777,          32'hFFFFFFFF, 9, 0, 0, 789});
        vecs.push_back('{"sub",   3'b010, 6'h22, 5,            10,           0,            0, 1, 0, 1, 3'b000, 32'h100,      32'hFFFFFFFB, 5, 1, 0, 32'h100});
        vecs.push_back('{"and",   3'b010, 6'h24, 32'hF0F000FF, 32'h0FF00F0F, 0,            0, 1, 0, 1, 3'b000, 32'h100,      32'h00F0000F, 5, 1, 0, 32'h100});
        vecs.push_back('{"or",    3'b010, 6'h25, 32'hF0000000, 32'h0000000F, 0,            0, 1, 0, 1, 3'b000, 32'h100,      32'hF000000F, 5, 1, 0, 32'h100});
        vecs.push_back('{"nor",   3'b010, 6'h27, 32'hFFFF0000, 32'h0000FF00, 0,            0, 1, 0, 1, 3'b000, 32'h100,      32'h000000FF, 5, 1, 0, 32'h100});
        vecs.push_back('{"slt_1", 3'b010, 6'h2A, 32'hFFFFFFFE, 1,            0,            0, 1, 0, 1, 3'b000, 32'h100,      1,            5, 1, 0, 32'h100});
        vecs.push_back('{"slt_0", 3'b010, 6'h2A, 1,            32'hFFFFFFFE, 0,            0, 1, 0, 1, 3'b000, 32'h100,      0,            5, 1, 0, 32'h100});
        vecs.push_back('{"bad_f", 3'b010, 6'h3F, 12,           34,           0,            0, 1, 0, 1, 3'b000, 32'h100,      0,            5, 0, 0, 32'h100});
        vecs.push_back('{"andi",  3'b011, 6'h00, 32'h12345678, 32'hDEAD,     32'h0000FFFF, 1, 0, 0, 1, 3'b000, 32'h100,      32'h5678,     9, 1, 0, 32'h400FC});
        vecs.push_back('{"ori",   3'b100, 6'h00, 32'h0F,       0,            32'hF0,       1, 0, 0, 1, 3'b000, 32'h100,      32'hFF,       9, 1, 0, 32'h4C0});
        vecs.push_back('{"slti",  3'b101, 6'h00, 32'hFFFFFFFF, 0,            0,            0, 0, 0, 1, 3'b000, 32'h100,      1,            9, 1, 0, 32'h100});
        vecs.push_back('{"add110",3'b110, 6'h00, 32'hFFFFFFFF, 2,            0,            0, 0, 0, 1, 3'b000, 32'h100,      1,            9, 1, 0, 32'h100});
        vecs.push_back('{"add111",3'b111, 6'h00, 40,           2,            0,            0, 0, 0, 1, 3'b000, 32'h100,      42,           9, 1, 0, 32'h100});
        vecs.push_back('{"lw",    3'b000, 6'h00, 100,          32'h55,       8,            1, 0, 0, 1, 3'b110, 32'h100,      108,          9, 1, 0, 32'h120});
        vecs.push_back('{"sw",    3'b000, 6'h00, 100,          32'h77,       4,            1, 0, 0, 0, 3'b001, 32'h100,      104,          9, 0, 0, 32'h110});
        vecs.push_back('{"tgt_wr",3'b001, 6'h00, 0,            0,            2,            0, 0, 1, 0, 3'b000, 32'hFFFFFFFC, 0,            9, 0, 1, 4});
        vecs.push_back('{"tgt_ng",3'b001, 6'h00, 1,            2,            32'hFFFFFFFF, 0, 0, 1, 0, 3'b000, 32'h100,      32'hFFFFFFFF, 9, 0, 0, 32'hFC});

        foreach (vecs[i]) begin
            drive(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b,
                  vecs[i].imm, vecs[i].src, vecs[i].dst, vecs[i].br,
                  vecs[i].rw, vecs[i].ctl, vecs[i].npc);
            edge1();
            chk({vecs[i].name, ".alu"}, alu_result_output, vecs[i].e_alu);
            chk({vecs[i].name, ".wreg"}, write_register_output, vecs[i].e_wr);
            chk({vecs[i].name, ".regwrite"}, RegWrite_output, vecs[i].e_rw);
            chk({vecs[i].name, ".taken"}, branch_taken_output, vecs[i].e_tk);
            chk({vecs[i].name, ".target"}, branch_target_output, vecs[i].e_tgt);
            chk({vecs[i].name, ".wdata"}, write_data_output, vecs[i].b);
            chk({vecs[i].name, ".mem"},
                {MemtoReg_output, MemRead_output, MemWrite_output}, vecs[i].ctl);
            chk({vecs[i].name, ".busy"}, busy, 0);
        end

        // Freeze: a loaded lw must survive three hit=0 edges.
        drive(3'b000, 6'h00, 100, 32'h55, 8, 1, 0, 0, 1, 3'b110, 32'h200);
        edge1();
        chk("frz.load", alu_result_output, 108);
        hit = 1'b0;
        drive(3'b010, 6'h20, 1, 2, 0, 0, 1, 0, 1, 3'b000, 32'h300);
        for (int k = 0; k < 3; k++) begin
            edge1();
            chk($sformatf("frz.hold%0d.alu", k), alu_result_output, 108);
            chk($sformatf("frz.hold%0d.wreg", k), write_register_output, 9);
            chk($sformatf("frz.hold%0d.mrd", k), MemRead_output, 1);
            chk($sformatf("frz.hold%0d.tgt", k), branch_target_output, 32'h220);
        end
        hit = 1'b1;
        edge1();
        chk("frz.release.alu", alu_result_output, 3);
        chk("frz.release.wreg", write_register_output, 5);
        chk("frz.release.mrd", MemRead_output, 0);

        // Mid-cycle reset with random inputs clears outputs at once.
        #2;
        reset_n = 1'b0;
        drive(3'b010, 6'h18, $urandom, $urandom, $urandom, 0, 1, 1, 1,
              3'($urandom), $urandom);
        #1;
        chk_all_zero("reset_mid");
        drive(3'b010, 6'h20, 111, 222, 0, 0, 1, 0, 1, 3'b000, 0);
        reset_n = 1'b1;
        edge1();
        chk("post_reset.alu", alu_result_output, 333);

`ifdef EXECUTE_MULT_EN
        drive(3'b010, 6'h18, 6, 7, 0, 0, 1, 0, 1, 3'b000, 0);
        #1;
        run_mul("mul1", 0, 33, 42);
        drive(3'b010, 6'h18, 32'hFFFFFFFF, 3, 0, 0, 1, 0, 1, 3'b000, 0);
        #1;
        run_mul("mul2_gap", 10, 38, 32'hFFFFFFFD);

        // Abort at counter 10, then an add must take one cycle.
        drive(3'b010, 6'h18, 9, 9, 0, 0, 1, 0, 1, 3'b000, 0);
        for (int k = 0; k < 11; k++) edge1();
        chk("abort.busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        drive(3'b010, 6'h20, 111, 222, 0, 0, 1, 0, 1, 3'b000, 0);
        reset_n = 1'b1;
        #1;
        chk("abort.add_busy", busy, 0);
        edge1();
        chk("abort.add.alu", alu_result_output, 333);
        chk("abort.add.regwrite", RegWrite_output, 1);
        chk("abort.add.wreg", write_register_output, 5);
`else
        // Without the multiplier funct 18 is an unknown op.
        drive(3'b010, 6'h18, 6, 7, 0, 0, 1, 0, 1, 3'b000, 0);
        #1;
        chk("nomul.busy", busy, 0);
        edge1();
        chk("nomul.alu", alu_result_output, 0);
        chk("nomul.regwrite", RegWrite_output, 0);
        chk("nomul.wreg", write_register_output, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
